// File: rtl/uart_tx_readout_pkg.sv
// Shared constants for the DAQ serial link: frame characters, host opcodes
// and the readout FSM state encoding.
package uart_tx_readout_pkg;

   localparam logic [7:0] DEF_HDR_CHAR = 8'h24;  // '$'
   localparam logic [7:0] DEF_TRL_CHAR = 8'h23;  // '#'
   localparam logic [7:0] DEF_ERR_CHAR = 8'h21;  // '!'

   // Opcodes decoded by the host-command receiver on the same link.
   localparam logic [7:0] OP_READ_DATA  = 8'h52;  // 'R'
   localparam logic [7:0] OP_WRITE_DATA = 8'h57;  // 'W'
   localparam logic [7:0] OP_STATUS     = 8'h53;  // 'S'

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HDR   = 3'd1,
      ST_ERR   = 3'd2,
      ST_REQ   = 3'd3,
      ST_WAIT  = 3'd4,
      ST_SEND  = 3'd5,
      ST_TRL   = 3'd6,
      ST_FLUSH = 3'd7
   } rd_state_t;

endpackage

// File: rtl/uart_tx_readout_serializer.sv
// 8N1 transmitter timed purely by en_16_x_baud strobes, with a one-byte
// holding register so consecutive bytes go out with no idle bits between them.
module uart_tx_serializer (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       en_16_x_baud,
   input  logic       load,
   input  logic [7:0] data,
   output logic       ready,
   output logic       tx,
   output logic       active
);

   logic [7:0] hold;
   logic       hold_valid;
   logic       shifting;
   logic [9:0] shreg;
   logic [3:0] strobe_cnt;
   logic [3:0] bit_cnt;

   // Handshake: a byte is taken when load and ready are both high in one clk;
   // ready drops the following clk and returns once the byte starts shifting.
   assign ready  = !hold_valid;
   assign active = hold_valid || shifting;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold       <= '0;
         hold_valid <= 1'b0;
         shifting   <= 1'b0;
         shreg      <= '1;
         strobe_cnt <= '0;
         bit_cnt    <= '0;
         tx         <= 1'b1;
      end else begin
         if (load && !hold_valid) begin
            hold       <= data;
            hold_valid <= 1'b1;
         end
         if (en_16_x_baud) begin
            // The start bit only ever begins on a strobe: from idle, or
            // directly on the strobe that ends the previous stop bit.
            if (!shifting || (strobe_cnt == 4'd15 && bit_cnt == 4'd9)) begin
               if (hold_valid) begin
                  shreg      <= {1'b1, hold, 1'b0};
                  tx         <= 1'b0;
                  hold_valid <= 1'b0;
                  shifting   <= 1'b1;
                  strobe_cnt <= '0;
                  bit_cnt    <= '0;
               end else begin
                  shifting <= 1'b0;
                  tx       <= 1'b1;
               end
            end else if (strobe_cnt == 4'd15) begin
               strobe_cnt <= '0;
               bit_cnt    <= bit_cnt + 4'd1;
               shreg      <= {1'b1, shreg[9:1]};
               tx         <= shreg[1];
            end else begin
               strobe_cnt <= strobe_cnt + 4'd1;
            end
         end
      end
   end

endmodule

// File: rtl/uart_tx_readout.sv
// Host-bound readout: on cntrlReadData, reads a word-address range from memory
// and streams it as '$' + LS-byte-first data + '#' over the UART.
module uart_tx_readout import uart_tx_readout_pkg::*; #(
   parameter int         ADDR_W     = 30,
   parameter int         DATA_BYTES = 4,
   parameter logic [7:0] HDR_CHAR   = DEF_HDR_CHAR,
   parameter logic [7:0] TRL_CHAR   = DEF_TRL_CHAR,
   parameter logic [7:0] ERR_CHAR   = DEF_ERR_CHAR
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    en_16_x_baud,
   input  logic                    cntrlReadData,
   input  logic [ADDR_W-1:0]       readAddrStart,
   input  logic [ADDR_W-1:0]       readAddrEnd,
   output logic                    memRdReq,
   output logic [ADDR_W-1:0]       memRdAddr,
   input  logic                    memRdValid,
   input  logic [8*DATA_BYTES-1:0] memRdData,
   output logic                    uart_tx,
   output logic                    txBusy,
   output logic                    txDone,
   output logic [2:0]              dbg_state
);

   localparam int IDX_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BYTES - 1);

   rd_state_t                   state;
   logic [ADDR_W-1:0]           addr;
   logic [ADDR_W-1:0]           end_addr;
   logic [DATA_BYTES-1:0][7:0]  word_buf;
   logic [IDX_W-1:0]            byte_idx;
   logic                        ser_ready;
   logic                        ser_active;
   logic                        ser_load;
   logic [7:0]                  ser_data;

   assign dbg_state = state;

   always_comb begin
      ser_load = 1'b0;
      ser_data = HDR_CHAR;
      case (state)
         ST_HDR:  ser_load = ser_ready;
         ST_ERR:  begin ser_load = ser_ready; ser_data = ERR_CHAR;           end
         ST_SEND: begin ser_load = ser_ready; ser_data = word_buf[byte_idx]; end
         ST_TRL:  begin ser_load = ser_ready; ser_data = TRL_CHAR;           end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         addr      <= '0;
         end_addr  <= '0;
         word_buf  <= '0;
         byte_idx  <= '0;
         memRdReq  <= 1'b0;
         memRdAddr <= '0;
         txBusy    <= 1'b0;
         txDone    <= 1'b0;
      end else begin
         memRdReq <= 1'b0;
         txDone   <= 1'b0;
         case (state)
            // A start pulse coinciding with txDone belongs to the frame just ended.
            ST_IDLE: if (cntrlReadData && !txDone) begin
               addr     <= readAddrStart;
               end_addr <= readAddrEnd;
               txBusy   <= 1'b1;
               state    <= ST_HDR;
            end
            ST_HDR: if (ser_ready) state <= (addr > end_addr) ? ST_ERR : ST_REQ;
            ST_ERR: if (ser_ready) state <= ST_TRL;
            ST_REQ: begin
               memRdReq  <= 1'b1;
               memRdAddr <= addr;
               state     <= ST_WAIT;
            end
            ST_WAIT: if (memRdValid) begin
               word_buf <= memRdData;
               byte_idx <= '0;
               state    <= ST_SEND;
            end
            // Stopping at end_addr, rather than on wrap, keeps the top address legal.
            ST_SEND: if (ser_ready) begin
               if (byte_idx == LAST_IDX) begin
                  if (addr == end_addr) begin
                     state <= ST_TRL;
                  end else begin
                     addr  <= addr + 1'b1;
                     state <= ST_REQ;
                  end
               end else begin
                  byte_idx <= byte_idx + 1'b1;
               end
            end
            ST_TRL: if (ser_ready) state <= ST_FLUSH;
            ST_FLUSH: if (!ser_active) begin
               txDone <= 1'b1;
               txBusy <= 1'b0;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   uart_tx_serializer u_ser (
      .clk          (clk),
      .reset_n      (reset_n),
      .en_16_x_baud (en_16_x_baud),
      .load         (ser_load),
      .data         (ser_data),
      .ready        (ser_ready),
      .tx           (uart_tx),
      .active       (ser_active)
   );

endmodule

// File: tb/tb_uart_tx_readout.sv
// Bench for uart_tx_readout: strobe-counting UART decoder, latency-programmable
// memory responder, and a frame model built from the address range.
module tb_uart_tx_readout;

   localparam int ADDR_W = 30;
   localparam int DW     = 32;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              en_16_x_baud = 1'b0;
   logic              cntrlReadData = 1'b0;
   logic [ADDR_W-1:0] readAddrStart = '0;
   logic [ADDR_W-1:0] readAddrEnd = '0;
   logic              memRdReq;
   logic [ADDR_W-1:0] memRdAddr;
   logic              memRdValid = 1'b0;
   logic [DW-1:0]     memRdData = '0;
   logic              uart_tx;
   logic              txBusy;
   logic              txDone;
   logic [2:0]        dbg_state;

   uart_tx_readout dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .en_16_x_baud  (en_16_x_baud),
      .cntrlReadData (cntrlReadData),
      .readAddrStart (readAddrStart),
      .readAddrEnd   (readAddrEnd),
      .memRdReq      (memRdReq),
      .memRdAddr     (memRdAddr),
      .memRdValid    (memRdValid),
      .memRdData     (memRdData),
      .uart_tx       (uart_tx),
      .txBusy        (txBusy),
      .txDone        (txDone),
      .dbg_state     (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] mem [logic [29:0]];
   logic [7:0]  exp_q[$];
   logic [7:0]  rx_q[$];
   logic [29:0] exp_req_q[$];
   logic [29:0] req_q[$];
   longint      start_q[$];

   longint      cyc = 0, strobe_n = 0, pulse_cyc = 0, exp_first_strobe = -1;
   bit          lat_armed = 0, arm_lat = 0, pulse_req = 0, pulse_on_done = 0, stray_en = 0;
   int          cur_lat = 1, resp_cnt = 0, stray_cnt = 0, done_count = 0;
   logic [29:0] resp_addr = '0;
   bit          rx_active = 0;
   int          rx_bit = 0;
   longint      rx_start = 0;
   logic [7:0]  rx_byte = '0;
   logic        tx_prev = 1'b1;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endfunction

   // One negedge process: count strobes, decode the line, count requests and
   // txDone, then drive the next cycle's strobe, start pulse and memory reply.
   initial begin
      forever begin
         @(negedge clk);
         if (en_16_x_baud) begin
            strobe_n++;
            if (lat_armed && cyc >= pulse_cyc + 2) begin
               exp_first_strobe = strobe_n;
               lat_armed = 0;
            end
         end
         if (!reset_n) begin
            rx_active = 0;
            tx_prev   = 1'b1;
            resp_cnt  = 0;
            stray_cnt = 0;
         end else begin
            if (txDone) done_count++;
            if (memRdReq) begin
               req_q.push_back(memRdAddr);
               resp_addr = memRdAddr;
               resp_cnt  = cur_lat + 1;
            end
            if (rx_active) begin
               if (uart_tx !== tx_prev) check("bit_edge_align", (strobe_n - rx_start) % 16, 0);
               if (en_16_x_baud && strobe_n == rx_start + 16 * rx_bit + 8) begin
                  if (rx_bit == 0) check("start_bit", uart_tx, 0);
                  else if (rx_bit <= 8) rx_byte = {uart_tx, rx_byte[7:1]};
                  else begin
                     check("stop_bit", uart_tx, 1);
                     rx_q.push_back(rx_byte);
                     start_q.push_back(rx_start);
                     rx_active = 0;
                  end
                  rx_bit++;
               end
            end else if (tx_prev === 1'b1 && uart_tx === 1'b0) begin
               check("start_on_strobe", en_16_x_baud, 1);
               rx_active = 1;
               rx_start  = strobe_n;
               rx_bit    = 0;
            end
            tx_prev = uart_tx;
         end
         cyc++;
         en_16_x_baud  = ($urandom_range(0, 1) == 1);
         cntrlReadData = pulse_req || (pulse_on_done && txDone);
         if (pulse_on_done && txDone) pulse_on_done = 0;
         if (pulse_req) begin
            pulse_cyc = cyc;
            lat_armed = arm_lat;
            pulse_req = 0;
         end
         memRdValid = 1'b0;
         memRdData  = $urandom;
         if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
               memRdValid = 1'b1;
               memRdData  = mem.exists(resp_addr) ? mem[resp_addr] : 32'h0;
               if (stray_en) stray_cnt = 3;
            end
         end else if (stray_cnt > 0) begin
            stray_cnt--;
            if (stray_cnt == 0) memRdValid = 1'b1;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic fill_mem(input logic [29:0] s, input logic [29:0] e, input int kind);
      for (longint a = s; a <= e; a++) begin
         logic [29:0] ad;
         ad = a[29:0];
         case (kind)
            0:       mem[ad] = 32'(a) * 32'h01010101;
            1:       mem[ad] = 32'hDDCCBBAA;
            default: mem[ad] = $urandom;
         endcase
      end
   endtask

   // Reference frame: header, each word LS byte first (or the error byte), trailer.
   task automatic build_expect(input logic [29:0] s, input logic [29:0] e);
      exp_q.delete();
      exp_req_q.delete();
      exp_q.push_back(8'h24);
      if (s > e) exp_q.push_back(8'h21);
      else begin
         for (longint a = s; a <= e; a++) begin
            logic [29:0] ad;
            logic [31:0] w;
            ad = a[29:0];
            w  = mem[ad];
            exp_req_q.push_back(ad);
            for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
         end
      end
      exp_q.push_back(8'h23);
   endtask

   task automatic run_frame(input logic [29:0] s, input logic [29:0] e, input int lat,
                            input bit extra, input bit on_done, input int exp_bytes,
                            input int exp_reqs, input string tag);
      int d0, budget, nb, nr;
      build_expect(s, e);
      readAddrStart = s;
      readAddrEnd   = e;
      cur_lat       = lat;
      rx_q.delete();
      start_q.delete();
      req_q.delete();
      d0 = done_count;
      exp_first_strobe = -1;
      pulse_on_done = on_done;
      arm_lat   = 1;
      pulse_req = 1;
      wait_cycles(4);
      check({tag, "_busy_after_start"}, txBusy, 1);
      readAddrStart = $urandom;
      readAddrEnd   = $urandom;
      budget = exp_q.size() * 160 * 4 + 2000;
      for (int i = 0; i < budget && done_count == d0; i++) begin
         wait_cycles(1);
         if (extra && i == 400) begin
            arm_lat   = 0;
            pulse_req = 1;
         end
      end
      check({tag, "_frame_done"}, done_count - d0, 1);
      wait_cycles(20);
      check({tag, "_busy_after_done"}, txBusy, 0);
      check({tag, "_done_count"}, done_count - d0, 1);
      check({tag, "_byte_count"}, rx_q.size(), exp_bytes);
      check({tag, "_req_count"}, req_q.size(), exp_reqs);
      nb = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
      for (int i = 0; i < nb; i++) check($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
      nr = (req_q.size() < exp_req_q.size()) ? req_q.size() : exp_req_q.size();
      for (int i = 0; i < nr; i++) check($sformatf("%s_req%0d", tag, i), req_q[i], exp_req_q[i]);
      for (int i = 1; i < start_q.size(); i++)
         check($sformatf("%s_gap%0d", tag, i), start_q[i] - start_q[i-1], 160);
      if (start_q.size() > 0) check({tag, "_first_start_latency"}, start_q[0], exp_first_strobe);
      pulse_on_done = 0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [29:0] s;
      logic [29:0] e;
      int          lat;
      int          kind;
      bit          extra;
      bit          on_done;
      int          exp_bytes;
      int          exp_reqs;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int    d0, rs, re, ok;
      bit    txlow;
      vecs[0] = '{30'd5, 30'd5, 3, 1, 0, 0, 6, 1};
      vecs[1] = '{30'd0, 30'd3, 2, 0, 0, 0, 18, 4};
      vecs[2] = '{30'd9, 30'd4, 1, 0, 0, 0, 3, 0};
      vecs[3] = '{30'd0, 30'd1, 5, 0, 1, 0, 10, 2};
      vecs[4] = '{30'h3FFFFFFF, 30'h3FFFFFFF, 1, 2, 0, 0, 6, 1};
      vecs[5] = '{30'h3FFFFFFE, 30'h3FFFFFFF, 4, 2, 0, 0, 10, 2};
      vecs[6] = '{30'd7, 30'd7, 1, 0, 0, 1, 6, 1};

      reset_n = 1'b0;
      wait_cycles(3);
      check("rst_uart_tx", uart_tx, 1);
      check("rst_memRdReq", memRdReq, 0);
      check("rst_memRdAddr", memRdAddr, 0);
      check("rst_txBusy", txBusy, 0);
      check("rst_txDone", txDone, 0);
      reset_n = 1'b1;
      wait_cycles(5);

      for (int v = 0; v < 7; v++) begin
         fill_mem(vecs[v].s, vecs[v].e, vecs[v].kind);
         run_frame(vecs[v].s, vecs[v].e, vecs[v].lat, vecs[v].extra, vecs[v].on_done,
                   vecs[v].exp_bytes, vecs[v].exp_reqs, $sformatf("vec%0d", v));
      end

      // Randomized ranges with stray memRdValid pulses outside the read wait.
      stray_en = 1;
      for (int r = 0; r < 4; r++) begin
         rs = $urandom_range(1, 1000);
         if ($urandom_range(0, 3) == 0) re = rs - 1;
         else re = rs + $urandom_range(0, 1);
         fill_mem(30'(rs), 30'(re), 2);
         run_frame(30'(rs), 30'(re), $urandom_range(1, 20), 0, 0,
                   (rs > re) ? 3 : 2 + 4 * (re - rs + 1), (rs > re) ? 0 : re - rs + 1,
                   $sformatf("rnd%0d", r));
      end
      stray_en = 0;

      // Reset during the 2nd data bit of the first data byte (all-zero word).
      mem[30'd20] = 32'h0;
      readAddrStart = 30'd20;
      readAddrEnd   = 30'd20;
      cur_lat = 2;
      arm_lat = 0;
      rx_q.delete();
      d0 = done_count;
      pulse_req = 1;
      ok = 0;
      for (int i = 0; i < 6000; i++) begin
         wait_cycles(1);
         if (rx_q.size() >= 1 && rx_active && strobe_n >= rx_start + 36) begin
            ok = 1;
            break;
         end
      end
      check("reset_point_reached", ok, 1);
      check("pre_reset_tx_low", uart_tx, 0);
      reset_n = 1'b0;
      #1;
      check("reset_tx_high", uart_tx, 1);
      check("reset_busy_low", txBusy, 0);
      check("reset_req_low", memRdReq, 0);
      wait_cycles(4);
      reset_n = 1'b1;
      txlow = 0;
      for (int i = 0; i < 3000; i++) begin
         wait_cycles(1);
         if (uart_tx !== 1'b1) txlow = 1;
      end
      check("no_done_after_reset", done_count - d0, 0);
      check("line_idle_after_reset", txlow, 0);
      check("busy_idle_after_reset", txBusy, 0);
      run_frame(30'd20, 30'd20, 2, 0, 0, 6, 1, "post_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
